// File: rtl/store_drain_buffer.sv
// store_drain_buffer: post-commit store FIFO draining to data memory.
// `define STORE_FWD_EN enables byte-granular load forwarding.
module store_drain_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_data,
  input  logic [2:0]       in_func3,
  input  logic [4:0]       in_rob_tag,
  output logic             mem_req,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic             mem_ack,
  input  logic             fwd_valid,
  input  logic [31:0]      fwd_addr,
  input  logic [2:0]       fwd_func3,
  output logic             fwd_hit,
  output logic             fwd_conflict,
  output logic [31:0]      fwd_data,
  output logic             err_pulse,
  output logic [4:0]       err_rob_tag,
  output logic [CNT_W-1:0] count,
  output logic             empty
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic {IDLE, REQ} state_t;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sdb_entry_t;

  sdb_entry_t       ent_q [DEPTH];
  sdb_entry_t       head_e;
  logic [PTR_W-1:0] head_q, tail_q;
  logic [CNT_W-1:0] count_q, count_d;
  state_t           state_q, state_d;
  logic             push, wr, pop, enc_ok;
  logic [31:0]      enc_data;
  logic [3:0]       enc_strb;

  always_comb begin
    enc_ok   = 1'b0;
    enc_strb = 4'b0000;
    enc_data = 32'h0;
    unique case (1'b1)
      in_func3 == 3'b000: begin
        enc_ok   = 1'b1;
        enc_strb = 4'b0001 << in_addr[1:0];
        enc_data = {24'h0, in_data[7:0]} << {in_addr[1:0], 3'b000};
      end
      in_func3 == 3'b001: begin
        enc_ok   = ~in_addr[0];
        enc_strb = 4'b0011 << in_addr[1:0];
        enc_data = {16'h0, in_data[15:0]} << {in_addr[1:0], 3'b000};
      end
      in_func3 == 3'b010: begin
        enc_ok   = (in_addr[1:0] == 2'b00);
        enc_strb = 4'b1111;
        enc_data = in_data;
      end
      default: ;
    endcase
  end

  // Rejected stores still complete the handshake; only the write is skipped.
  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign wr       = push & enc_ok;
  assign pop      = (state_q == REQ) & mem_ack;
  assign count_d  = count_q + CNT_W'(wr) - CNT_W'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else if (wr) begin
      ent_q[tail_q] <= '{waddr: in_addr[31:2],
                         data:  enc_data,
                         strb:  enc_strb};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      err_pulse   <= 1'b0;
      err_rob_tag <= 5'h0;
    end else begin
      count_q   <= count_d;
      err_pulse <= push & ~enc_ok;
      if (wr)  tail_q <= tail_q + 1'b1;
      if (pop) head_q <= head_q + 1'b1;
      if (push & ~enc_ok) err_rob_tag <= in_rob_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (count_q != '0) state_d = REQ;
      REQ:  if (pop && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign head_e    = ent_q[head_q];
  assign mem_req   = (state_q == REQ);
  assign mem_addr  = mem_req ? {head_e.waddr, 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? head_e.data : 32'h0;
  assign mem_wstrb = mem_req ? head_e.strb : 4'h0;
  assign count     = count_q;
  assign empty     = (count_q == '0) && (state_q == IDLE);

`ifdef STORE_FWD_EN
  logic [3:0]       cov, req_m;
  logic [31:0]      mrg;
  logic [PTR_W-1:0] idx;
  logic             fwd_unused;

  // Walk oldest to youngest so later stores overwrite earlier bytes.
  always_comb begin
    cov = 4'h0;
    mrg = 32'h0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && ent_q[idx].waddr == fwd_addr[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_q[idx].strb[b]) begin
            cov[b]         = 1'b1;
            mrg[8*b +: 8]  = ent_q[idx].data[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    req_m = 4'b1111;
    unique case (1'b1)
      fwd_func3[1:0] == 2'b00: req_m = 4'b0001 << fwd_addr[1:0];
      fwd_func3[1:0] == 2'b01: req_m = 4'b0011 << fwd_addr[1:0];
      default: ;
    endcase
  end

  assign fwd_hit      = fwd_valid & ((cov & req_m) == req_m);
  assign fwd_conflict = fwd_valid & (|(cov & req_m)) & ~fwd_hit;
  assign fwd_data     = fwd_valid ? mrg : 32'h0;
  assign fwd_unused   = fwd_func3[2];
`else
  logic             any_m;
  logic [PTR_W-1:0] idx;
  logic             fwd_unused;

  // Without forwarding, any word overlap forces a conservative replay.
  always_comb begin
    any_m = 1'b0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (CNT_W'(i) < count_q && ent_q[idx].waddr == fwd_addr[31:2])
        any_m = 1'b1;
    end
  end

  assign fwd_hit      = 1'b0;
  assign fwd_data     = 32'h0;
  assign fwd_conflict = fwd_valid & any_m;
  assign fwd_unused   = ^{fwd_addr[1:0], fwd_func3};
`endif

endmodule

// File: doc/store_drain_buffer.md
Name: store_drain_buffer

Overview:
- Post-commit store buffer on the consumer side of the LSQ.
- The LSQ pushes each store once the ROB retires it. The block queues these architecturally committed stores in program order and drains them one at a time to data memory over a req/ack handshake.
- It also answers byte-granular forwarding lookups from the load pipe, so younger loads never read stale memory.

Parameters:
- DEPTH, 8, number of buffered stores; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, width of occupancy count.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  retired store offered by LSQ
- in_ready  out  1  buffer can accept
- in_addr  in  32  byte address (lsq.addr)
- in_data  in  32  store data (lsq.ps2_data), LSB-justified
- in_func3  in  3  000 sb, 001 sh, 010 sw
- in_rob_tag  in  5  tag, kept for debug/err reporting
- mem_req  out  1  write request
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-aligned data
- mem_wstrb  out  4  byte enables
- mem_ack  in  1  memory accepted current request
- fwd_valid  in  1  load lookup active
- fwd_addr  in  32  load byte address
- fwd_func3  in  3  load width (000/100 byte, 001/101 half, 010 word)
- fwd_hit  out  1  all requested bytes supplied by buffer
- fwd_conflict  out  1  load overlaps buffer but cannot be fully forwarded; load must replay
- fwd_data  out  32  merged word (raw lanes; load unit extracts/extends)
- err_pulse  out  1  one-cycle pulse: misaligned or illegal func3 store dropped
- err_rob_tag  out  5  tag of dropped store
- count  out  CNT_W  occupancy
- empty  out  1  count==0 and FSM IDLE

Behaviour:
- Reset (async assert, sync release):
  - all entries invalid; head/tail/count=0; FSM=IDLE.
  - mem_req=0, mem_addr/wdata/wstrb=0.
  - err_pulse=0, err_rob_tag=0; fwd_hit/conflict=0.
  - in_ready=1, empty=1.
- Reset mid-request: mem_req drops asynchronously; pending stores are lost; memory must tolerate an abandoned req.
- Push: accepted on edge where in_valid&in_ready. in_ready = (count<DEPTH); no pass-through when full, even if popping that cycle.
- Encoding at push:
  - sb: wstrb=4'b0001<<a[1:0], wdata=data[7:0] placed in lane a[1:0].
  - sh: requires a[0]=0; wstrb=4'b0011<<a[1:0], wdata=data[15:0]<<(8*a[1:0]).
  - sw: requires a[1:0]=0; wstrb=4'b1111.
  - Misaligned or other func3: entry not written; err_pulse=1 next cycle with err_rob_tag; in_ready handshake still completes.
- Pointers: head/tail wrap mod DEPTH. count updates +1 on push, -1 on pop, unchanged on both.
- FSM:
  - IDLE: go to REQ when count≠0 (next edge).
  - REQ: mem_req=1; mem_addr/wdata/wstrb driven from head entry and held stable until mem_ack.
  - On mem_ack in REQ: pop head. Stay REQ if count after pop ≠0, else IDLE. Back-to-back requests are allowed with no idle cycle.
- Latency: store accepted on edge E0 → mem_req high after E1. mem_ack in the same cycle as mem_req is legal.
- mem_ack outside REQ is ignored.
- Ordering: strictly FIFO; no write merging.

Optional Feature:
- Macro STORE_FWD_EN.
- Defined: combinational lookup over all valid entries, including the head in REQ.
  - Match on word address [31:2].
  - Bytes merged oldest→youngest into fwd_data.
  - fwd_hit=1 when every requested byte (from fwd_func3 and fwd_addr[1:0]) is covered.
  - fwd_conflict=1 when some but not all requested bytes are covered.
  - Both outputs are 0 when fwd_valid=0.
- Undefined: fwd_hit=0 and fwd_data=0 always; fwd_conflict=fwd_valid & any valid entry matching the word address (conservative replay).

Test Plan:
- Reset, push sw addr=0x100 data=0xDEADBEEF, mem_ack on 2nd REQ cycle → mem_req rises after E1; addr=0x100, wstrb=1111, wdata held 2 cycles; empty=1 afterward.
- Push sb addr=0x203 data=0x000000AB → wstrb=1000, wdata=0xAB000000, mem_addr=0x200.
- Fill DEPTH=8 with mem_ack=0 → in_ready=0 and count=8; 9th offer stalls; then ack every cycle → 8 back-to-back writes in order, pointers wrap correctly.
- Push sh addr=0x301 rob_tag=5 → no entry; err_pulse=1 for one cycle with err_rob_tag=5; count unchanged.
- STORE_FWD_EN: buffer holds sw 0x400=0x11223344 then sb 0x401=0xAA; lw 0x400 → hit=1, data=0x1122AA44. With only the sb buffered → lw conflict=1, lbu 0x401 hit=1.
- Macro undefined, same stores: lw 0x400 → hit=0, conflict=1. Assert rst_n low while mem_req=1 → mem_req=0 immediately, count=0.
